// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the serial detector (dout/cen -> din/cen), LSB first.
// Latency: bit 0 on dout one cycle after the accept edge; each bit lasts DIV cycles.
// Backpressure: in_ready only in IDLE or the final-bit cen cycle, which allows gapless streaming.
//
// Ports:
//   clk, resetn         : sole clock; synchronous active-low reset
//   in_valid/in_ready   : word handshake; in_data is the WIDTH-bit parallel word
//   dout, cen           : serial bit and per-bit sample strobe
//   busy, done          : word in flight; pulse in the cen cycle of the final bit
// Optional build macro: SER_PARITY_EN appends an even-parity bit after the MSB.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             dout,
  output logic             cen,
  output logic             busy,
  output logic             done
);

`ifdef SER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  // Holds in_ready low until the first edge after reset release.
  logic          rdy_en_q;

  logic          cen_w, last_w, accept_w;
  logic [N-1:0]  load_w;

`ifdef SER_PARITY_EN
  assign load_w = {^in_data, in_data};
`else
  assign load_w = in_data;
`endif

  // State register (together with the datapath registers).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    if (accept_w) begin
      state_d = S_SHIFT;
      sr_d    = load_w;
      div_d   = '0;
      bit_d   = '0;
    end else if (state_q == S_SHIFT) begin
      if (cen_w) begin
        // After the last bit the register has shifted down to all zeros,
        // so dout returns to 0 in IDLE without extra gating.
        sr_d  = sr_q >> 1;
        div_d = '0;
        if (last_w) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // Outputs: all decoded from registers only; in_valid feeds no output.
  always_comb begin
    cen_w    = (state_q == S_SHIFT) && (div_q == DIV_LAST);
    last_w   = cen_w && (bit_q == BIT_LAST);
    in_ready = rdy_en_q && ((state_q == S_IDLE) || last_w);
    accept_w = in_valid && in_ready;
    cen      = cen_w;
    done     = last_w;
    busy     = (state_q == S_SHIFT);
    dout     = sr_q[0];
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench: two serializers (DIV=1 and DIV=3) compared each cycle
// against a queue of expected (dout, cen, done) entries built per accepted word.
// Random resets, some mid-word, check that the partial word is discarded.
module tb_bit_serializer;
  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic dout;
    logic cen;
    logic done;
  } exp_t;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int DV = (gi == 0) ? 1 : 3;

    logic             in_valid, in_ready, dout, cen, busy, done;
    logic [WIDTH-1:0] in_data;
    logic [7:0]       dir [7];
    int               idx = 0;
    exp_t             q[$];
    logic             rdy_en = 1'b0;
    logic             acc;
    exp_t             e;
    exp_t             cur;

    bit_serializer #(.WIDTH(WIDTH), .DIV(DV)) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .dout     (dout),
      .cen      (cen),
      .busy     (busy),
      .done     (done)
    );

    // Driver: directed words first, then random data; valid ~75% of cycles.
    initial begin
      dir[0] = 8'h07; dir[1] = 8'hA5; dir[2] = 8'hF0; dir[3] = 8'h0F;
      dir[4] = 8'h55; dir[5] = 8'hFF; dir[6] = 8'h01;
      in_valid = 1'b0;
      in_data  = '0;
      forever begin
        @(posedge clk);
        #1;
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = (idx < 7) ? dir[idx] : WIDTH'($urandom);
      end
    end

    // Reference: each accepted word becomes NB*DV cycle entries; a word is
    // accepted when the stream has at most its final (done) cycle left.
    always @(posedge clk) begin
      if (!resetn) begin
        q.delete();
        rdy_en = 1'b0;
      end else begin
        acc = rdy_en && in_valid && (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) begin
          for (int k = 0; k < NB; k++) begin
            for (int d = 0; d < DV; d++) begin
              e.dout = (k < WIDTH) ? in_data[k] : ^in_data;
              e.cen  = (d == DV - 1);
              e.done = (d == DV - 1) && (k == NB - 1);
              q.push_back(e);
            end
          end
          idx++;
        end
        rdy_en = 1'b1;
      end
    end

    always @(negedge clk) begin
      cur = (q.size() > 0) ? q[0] : '0;
      check($sformatf("div%0d dout", DV), {7'd0, dout}, {7'd0, cur.dout});
      check($sformatf("div%0d cen", DV), {7'd0, cen}, {7'd0, cur.cen});
      check($sformatf("div%0d done", DV), {7'd0, done}, {7'd0, cur.done});
      check($sformatf("div%0d busy", DV), {7'd0, busy}, {7'd0, (q.size() > 0)});
      check($sformatf("div%0d in_ready", DV), {7'd0, in_ready},
            {7'd0, (rdy_en && (q.size() <= 1))});
    end
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      if (c > 300 && $urandom_range(0, 249) == 0) begin
        resetn = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 resetn = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
